// File: rtl/bfp_block_exponent_mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bfp_block_exponent_mc_pkg                                         |
// | Brief  : shared defaults, counter type and shift-width helper for BFP path |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package bfp_block_exponent_mc_pkg;

    localparam int C_DEF_WIDTH     = 16;
    localparam int C_DEF_NUM_CH    = 4;
    localparam int C_DEF_MAX_BLOCK = 1024;
    localparam int C_DEF_GUARD     = 1;

    typedef logic [$clog2(C_DEF_MAX_BLOCK+1)-1:0] blk_cnt_t;

    function automatic int shift_w(input int width);
        return $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bfp_block_exponent_mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bfp_block_exponent_mc_if                                          |
// | Brief  : sample input and valid/ready result bundle of the exponent engine |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface bfp_block_exponent_mc_if
    import bfp_block_exponent_mc_pkg::*;
#(
    parameter int WIDTH     = C_DEF_WIDTH,
    parameter int NUM_CH    = C_DEF_NUM_CH,
    parameter int MAX_BLOCK = C_DEF_MAX_BLOCK
);
    localparam int C_SHW   = shift_w(WIDTH);
    localparam int C_CNT_W = $clog2(MAX_BLOCK+1);

    logic                      i_valid;
    logic [NUM_CH*WIDTH-1:0]   i_data;
    logic [C_CNT_W-1:0]        i_block_len;
    logic                      i_flush;
    logic [NUM_CH*C_SHW-1:0]   o_shift;
    logic                      o_shift_valid;
    logic                      i_shift_ready;
    logic [C_CNT_W-1:0]        o_blk_samples;
    logic                      o_overrun;

    modport slave (
        input  i_valid, i_data, i_block_len, i_flush, i_shift_ready,
        output o_shift, o_shift_valid, o_blk_samples, o_overrun
    );

    modport master (
        output i_valid, i_data, i_block_len, i_flush, i_shift_ready,
        input  o_shift, o_shift_valid, o_blk_samples, o_overrun
    );
endinterface
`default_nettype wire

// File: rtl/bfp_block_exponent_mc_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bfp_lzc                                                           |
// | Brief  : combinational leading-zero count; all-zero input returns WIDTH    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module bfp_lzc #(
    parameter int WIDTH = 16
) (
    input  wire logic [WIDTH-1:0]           i_data,
    output logic      [$clog2(WIDTH+1)-1:0] o_lzc
);
    localparam int C_LZW = $clog2(WIDTH+1);

    // Scanning upward lets the highest set bit win without an early exit.
    always_comb begin
        o_lzc = C_LZW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) o_lzc = C_LZW'(WIDTH - 1 - i);
        end
    end
endmodule
`default_nettype wire

// File: rtl/bfp_block_exponent_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bfp_block_exponent_mc                                             |
// | Brief  : per-channel block peak tracking and normalising shift per block.  |
// |          BFP_COMMON_EXP_EN: one shared (minimum) shift, one extra stage.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module bfp_block_exponent_mc
    import bfp_block_exponent_mc_pkg::*;
#(
    parameter int WIDTH     = C_DEF_WIDTH,
    parameter int NUM_CH    = C_DEF_NUM_CH,
    parameter int MAX_BLOCK = C_DEF_MAX_BLOCK,
    parameter int GUARD     = C_DEF_GUARD
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    bfp_block_exponent_mc_if.slave bus
);
    localparam int C_SHW   = shift_w(WIDTH);
    localparam int C_CNT_W = $clog2(MAX_BLOCK+1);
    localparam int C_LZW   = $clog2(WIDTH+1);
    localparam logic [C_LZW-1:0] C_HEAD = C_LZW'(1 + GUARD);

    logic [C_CNT_W-1:0] r_cnt, r_len, w_len_in, w_len_cur, w_cnt_final, r_s1_cnt;
    logic               w_first, w_last_in, w_flush_idle, w_close, r_s1_valid;

    logic [NUM_CH-1:0][WIDTH-1:0] w_x, w_mag, w_fin, r_acc, r_s1_fin;
    logic [NUM_CH-1:0][C_LZW-1:0] w_lzc;
    logic [NUM_CH-1:0][C_SHW-1:0] w_sh, w_ld_sh, r_sh;
    logic                         w_ld_valid, r_valid, r_ovr;
    logic [C_CNT_W-1:0]           w_ld_cnt, r_blk;

    always_comb begin
        if (bus.i_block_len == '0)                       w_len_in = C_CNT_W'(1);
        else if (bus.i_block_len > C_CNT_W'(MAX_BLOCK))  w_len_in = C_CNT_W'(MAX_BLOCK);
        else                                             w_len_in = bus.i_block_len;
    end

    // Length is only taken from the port on a block's first sample.
    assign w_first      = (r_cnt == '0);
    assign w_len_cur    = w_first ? w_len_in : r_len;
    assign w_last_in    = bus.i_valid & (bus.i_flush | (r_cnt == w_len_cur - C_CNT_W'(1)));
    assign w_flush_idle = ~bus.i_valid & bus.i_flush & ~w_first;
    assign w_close      = w_last_in | w_flush_idle;
    assign w_cnt_final  = r_cnt + {{(C_CNT_W-1){1'b0}}, bus.i_valid};
    assign w_x          = bus.i_data;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // One's-complement fold keeps the leading-one position of negative values.
        assign w_mag[c] = w_x[c][WIDTH-1] ? ~w_x[c] : w_x[c];
        assign w_fin[c] = r_acc[c] | (bus.i_valid ? w_mag[c] : '0);

        bfp_lzc #(.WIDTH(WIDTH)) u_lzc (
            .i_data (r_s1_fin[c]),
            .o_lzc  (w_lzc[c])
        );

        assign w_sh[c] = (w_lzc[c] > C_HEAD) ? C_SHW'(w_lzc[c] - C_HEAD) : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_len      <= '0;
            r_acc      <= '0;
            r_s1_fin   <= '0;
            r_s1_cnt   <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            if (w_close)          r_cnt <= '0;
            else if (bus.i_valid) r_cnt <= r_cnt + C_CNT_W'(1);
            if (bus.i_valid && w_first) r_len <= w_len_in;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_close)          r_acc[c] <= '0;
                else if (bus.i_valid) r_acc[c] <= r_acc[c] | w_mag[c];
            end
            r_s1_valid <= w_close;
            if (w_close) begin
                r_s1_fin <= w_fin;
                r_s1_cnt <= w_cnt_final;
            end
        end
    end

`ifdef BFP_COMMON_EXP_EN
    logic [NUM_CH-1:0][C_SHW-1:0] r_s2_sh;
    logic                         r_s2_valid;
    logic [C_CNT_W-1:0]           r_s2_cnt;
    logic [C_SHW-1:0]             w_min;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_sh    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_cnt   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sh  <= w_sh;
                r_s2_cnt <= r_s1_cnt;
            end
        end
    end

    always_comb begin
        w_min = r_s2_sh[0];
        for (int c = 1; c < NUM_CH; c++) begin
            if (r_s2_sh[c] < w_min) w_min = r_s2_sh[c];
        end
        w_ld_sh = {NUM_CH{w_min}};
    end

    assign w_ld_valid = r_s2_valid;
    assign w_ld_cnt   = r_s2_cnt;
`else
    assign w_ld_sh    = w_sh;
    assign w_ld_valid = r_s1_valid;
    assign w_ld_cnt   = r_s1_cnt;
`endif

    // A new result always wins; overrun flags only a result nobody took.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh    <= '0;
            r_blk   <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_ld_valid) begin
                r_sh    <= w_ld_sh;
                r_blk   <= w_ld_cnt;
                r_valid <= 1'b1;
                r_ovr   <= r_valid & ~bus.i_shift_ready;
            end else if (r_valid && bus.i_shift_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.o_shift       = r_sh;
    assign bus.o_shift_valid = r_valid;
    assign bus.o_blk_samples = r_blk;
    assign bus.o_overrun     = r_ovr;
endmodule
`default_nettype wire

// File: tb/tb_bfp_block_exponent_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_bfp_block_exponent_mc                                          |
// | Brief  : vector table plus corner sequences, results checked on accept     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bfp_block_exponent_mc;
`ifdef BFP_COMMON_EXP_EN
    localparam int C_LAT    = 3;
    localparam bit C_COMMON = 1'b1;
`else
    localparam int C_LAT    = 2;
    localparam bit C_COMMON = 1'b0;
`endif

    typedef struct packed {
        logic [10:0]      len;
        logic [3:0]       n;
        logic [3:0]       flush_at;
        logic [0:7][15:0] d0;
        logic [0:7][15:0] d1;
        logic [3:0]       e0;
        logic [3:0]       e1;
        logic [10:0]      ecnt;
    } vec_t;

    typedef struct packed {
        logic [3:0]  e0;
        logic [3:0]  e1;
        logic [10:0] ecnt;
        int          t;
        logic        chk_lat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   npass = 0;
    int   ntot  = 0;
    int   novr  = 0;
    exp_t sb[$];
    vec_t vt[7];

    bfp_block_exponent_mc_if #(.WIDTH(16), .NUM_CH(2), .MAX_BLOCK(1024)) bus ();

    bfp_block_exponent_mc #(.WIDTH(16), .NUM_CH(2), .MAX_BLOCK(1024), .GUARD(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        ntot++;
        if (act == exp_v) npass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    task automatic push_exp(input logic [3:0] e0, input logic [3:0] e1,
                            input logic [10:0] c, input logic lat);
        exp_t e;
        logic [3:0] m;
        m         = (e0 < e1) ? e0 : e1;
        e.e0      = C_COMMON ? m : e0;
        e.e1      = C_COMMON ? m : e1;
        e.ecnt    = c;
        e.t       = cyc;
        e.chk_lat = lat;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic f, input logic [15:0] a,
                         input logic [15:0] b, input logic [10:0] len);
        @(posedge clk);
        #1;
        bus.i_valid     = v;
        bus.i_flush     = f;
        bus.i_data      = {b, a};
        bus.i_block_len = len;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 16'h0, 16'h0, 11'd0);
    endtask

    // Mid-block length is set to 3 so a design that reads it live ends blocks early.
    task automatic apply_vec(input vec_t v);
        for (int s = 0; s < int'(v.n); s++) begin
            drive(1'b1, (s == int'(v.flush_at)), v.d0[s], v.d1[s], (s == 0) ? v.len : 11'd3);
            if (s == int'(v.n) - 1) push_exp(v.e0, v.e1, v.ecnt, 1'b1);
        end
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1;
        bus.i_shift_ready = r;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
        chk("drain_pending", sb.size(), 0);
    endtask

    // Overwritten results are dropped from the front; accepted ones are compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_overrun) begin
                novr++;
                if (sb.size() != 0) void'(sb.pop_front());
            end
            if (bus.o_shift_valid && bus.i_shift_ready) begin
                if (sb.size() == 0) begin
                    ntot++;
                    $display("FAIL unexpected_result: got shift 0x%0h blk %0d, required none",
                             bus.o_shift, bus.o_blk_samples);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("shift_ch0", int'(bus.o_shift[3:0]), int'(e.e0));
                    chk("shift_ch1", int'(bus.o_shift[7:4]), int'(e.e1));
                    chk("blk_samples", int'(bus.o_blk_samples), int'(e.ecnt));
                    if (e.chk_lat) chk("latency", cyc - e.t, C_LAT);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovr0;
        vt[0] = '{len:11'd4, n:4'd4, flush_at:4'd15,
                  d0:{16'h0100, 16'h0020, 16'h0003, 16'h0000, 64'h0},
                  d1:{16'hFF00, 16'hFFF0, 16'hFFFF, 16'hFF80, 64'h0},
                  e0:4'd5, e1:4'd6, ecnt:11'd4};
        vt[1] = '{len:11'd1, n:4'd1, flush_at:4'd15,
                  d0:{16'h7FFF, 112'h0}, d1:{16'h8000, 112'h0},
                  e0:4'd0, e1:4'd0, ecnt:11'd1};
        vt[2] = '{len:11'd2, n:4'd2, flush_at:4'd15,
                  d0:{16'h0000, 16'h0000, 96'h0}, d1:{16'hFFFF, 16'hFFFF, 96'h0},
                  e0:4'd14, e1:4'd14, ecnt:11'd2};
        vt[3] = '{len:11'd8, n:4'd3, flush_at:4'd2,
                  d0:{16'h0001, 16'h0002, 16'h0004, 80'h0},
                  d1:{16'h0010, 16'hFFFE, 16'h0000, 80'h0},
                  e0:4'd11, e1:4'd9, ecnt:11'd3};
        vt[4] = '{len:11'd0, n:4'd1, flush_at:4'd15,
                  d0:{16'h4000, 112'h0}, d1:{16'h1000, 112'h0},
                  e0:4'd0, e1:4'd1, ecnt:11'd1};
        vt[5] = '{len:11'd3, n:4'd3, flush_at:4'd15,
                  d0:{16'h0400, 16'hFBFF, 16'h0001, 80'h0},
                  d1:{16'h0008, 16'h0000, 16'h0000, 80'h0},
                  e0:4'd3, e1:4'd10, ecnt:11'd3};
        vt[6] = '{len:11'd2, n:4'd2, flush_at:4'd1,
                  d0:{16'h0000, 16'h0002, 96'h0}, d1:{16'h0000, 16'h0000, 96'h0},
                  e0:4'd12, e1:4'd14, ecnt:11'd2};

        bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_data = '0;
        bus.i_block_len = '0; bus.i_shift_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", bus.o_shift_valid, 0);
        chk("reset_shift", int'(bus.o_shift), 0);
        chk("reset_blk", int'(bus.o_blk_samples), 0);
        chk("reset_overrun", bus.o_overrun, 0);
        #2 rst_n = 1'b1;

        drive(1'b0, 1'b1, 16'h0, 16'h0, 11'd4);
        idle(C_LAT + 3);
        chk("idle_flush_no_result", bus.o_shift_valid, 0);

        foreach (vt[i]) apply_vec(vt[i]);
        idle(1);
        wait_drain();

        // Flush on an idle cycle closes a two-sample partial block.
        drive(1'b1, 1'b0, 16'h0040, 16'h0000, 11'd4);
        drive(1'b1, 1'b0, 16'h0000, 16'h0300, 11'd4);
        drive(1'b0, 1'b1, 16'h0000, 16'h0000, 11'd4);
        push_exp(4'd7, 4'd4, 11'd2, 1'b1);
        idle(1);
        wait_drain();

        // Oversized length clamps to 1024; the next sample opens a fresh block.
        for (int s = 0; s < 1024; s++) begin
            drive(1'b1, 1'b0, (s == 500) ? 16'h0100 : 16'h0000, 16'h0000,
                  (s == 0) ? 11'd2000 : 11'd3);
            if (s == 1023) push_exp(4'd5, 4'd14, 11'd1024, 1'b1);
        end
        drive(1'b1, 1'b0, 16'h7FFF, 16'h0000, 11'd1);
        push_exp(4'd0, 4'd14, 11'd1, 1'b1);
        idle(1);
        wait_drain();

        ovr0 = novr;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 16'h0001 << (4 * k), 16'h0002, 11'd1);
            push_exp(4'(13 - 4 * k), 4'd12, 11'd1, 1'b1);
        end
        idle(1);
        wait_drain();
        chk("no_overrun_when_ready", novr - ovr0, 0);

        set_ready(1'b0);
        ovr0 = novr;
        drive(1'b1, 1'b0, 16'h0001, 16'h0000, 11'd1); push_exp(4'd13, 4'd14, 11'd1, 1'b0);
        drive(1'b1, 1'b0, 16'h0010, 16'h0000, 11'd1); push_exp(4'd9, 4'd14, 11'd1, 1'b0);
        drive(1'b1, 1'b0, 16'h0100, 16'h4000, 11'd1); push_exp(4'd5, 4'd0, 11'd1, 1'b0);
        idle(C_LAT + 3);
        chk("overrun_pulses", novr - ovr0, 2);
        chk("held_valid", bus.o_shift_valid, 1);
        set_ready(1'b1);
        wait_drain();

        // Reset with a held result and a partial block; both must be discarded.
        set_ready(1'b0);
        drive(1'b1, 1'b0, 16'h0100, 16'h0000, 11'd1);
        push_exp(4'd5, 4'd14, 11'd1, 1'b0);
        idle(C_LAT + 1);
        drive(1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 11'd4);
        drive(1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 11'd4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_valid", bus.o_shift_valid, 0);
        chk("midrst_shift", int'(bus.o_shift), 0);
        chk("midrst_blk", int'(bus.o_blk_samples), 0);
        chk("midrst_overrun", bus.o_overrun, 0);
        bus.i_valid = 1'b0;
        bus.i_shift_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        apply_vec(vt[0]);
        idle(1);
        wait_drain();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
`default_nettype wire
